paddle_ctrl: RTL
================

PADDLE_CTRL -- requirements
Module: paddle_ctrl

Interface
REQ-001 Parameter IDLE_TIMEOUT, default controller_pkg::IDLE_TIMEOUT (1_400_000), cycles without a qualifying pulse before the streak is cleared.
REQ-002 clk  input  1  system clock; all logic on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 btn_up  input  1  single-cycle move-up pulse from the debounce stage (decreases paddle_y).
REQ-005 btn_down  input  1  single-cycle move-down pulse from the debounce stage (increases paddle_y).
REQ-006 center  input  1  single-cycle request to return the paddle to Y_INIT.
REQ-007 freeze  input  1  level; high = game paused, movement inhibited.
REQ-008 paddle_y  output  10  paddle top-edge row, range 0..Y_MAX (Y_MAX = SCREEN_H - PADDLE_H = 520).
REQ-009 y_upd  output  1  one-cycle strobe, high in the cycle paddle_y takes a new value.
REQ-010 dir  output  2  current state: 00 IDLE, 01 UP, 10 DOWN.

Function
REQ-011 The FSM SHALL have states IDLE, UP, DOWN; dir SHALL reflect the registered state.
REQ-012 A qualifying pulse (exactly one of btn_up/btn_down high, center low, freeze low) SHALL update paddle_y on the next clock edge (latency 1), with y_upd high in that same cycle.
REQ-013 A 4-bit streak counter SHALL count consecutive same-direction pulses, saturating at 15; a pulse in the current direction increments it; a pulse from IDLE or the opposite direction sets it to 1 and moves the state to UP/DOWN accordingly.
REQ-014 Step size SHALL be computed from the post-update streak n: n=1..4 -> STEP_BASE (4), n=5..8 -> 8, n>=9 -> STEP_MAX (16).
REQ-015 Up moves SHALL compute paddle_y - step, saturated at 0; down moves SHALL compute paddle_y + step, saturated at Y_MAX; arithmetic SHALL use 11 bits, no wrap-around.
REQ-016 A move that leaves paddle_y unchanged due to saturation SHALL NOT assert y_upd, but SHALL still update streak and state.
REQ-017 btn_up and btn_down high in the same cycle SHALL cause no move, clear streak to 0, enter IDLE, no y_upd.
REQ-018 center SHALL have priority over all pulses: paddle_y <= Y_INIT (260), streak 0, state IDLE, y_upd high if the value changed.
REQ-019 freeze high SHALL drop btn_up/btn_down pulses and hold the idle timer; center SHALL still act during freeze.
REQ-020 The idle timer SHALL count cycles in UP/DOWN, reset on every qualifying pulse, and on reaching IDLE_TIMEOUT SHALL clear streak and enter IDLE the next cycle.
REQ-021 A pulse arriving in the same cycle as timeout expiry SHALL take priority (treated as a continuing streak).

Reset
REQ-022 On rst: paddle_y = Y_INIT (260), y_upd = 0, dir = IDLE, streak = 0, idle timer = 0.
REQ-023 rst asserted mid-streak or mid-timeout SHALL discard all history; the first pulse after reset uses step 4.

Structure
REQ-024 controller_pkg SHALL hold SCREEN_H (600), PADDLE_H (80), Y_MAX, Y_INIT, STEP_BASE, STEP_MAX, ACCEL_PULSES (4), IDLE_TIMEOUT and the paddle_state_t enum.
REQ-025 The idle timer SHALL be a sub-module idle_timer (clear, hold, expire outputs), 21-bit counter.
REQ-026 Two paddle_ctrl instances (left/right player) SHALL be instantiable with no shared state.

Verification
REQ-027 Reset, no stimulus -> paddle_y=260, dir=00, y_upd=0 for 100 cycles.
REQ-028 3 btn_up pulses 100 cycles apart -> paddle_y 256, 252, 248, each with one y_upd strobe one cycle after the pulse.
REQ-029 From reset, 10 btn_down pulses -> steps 4,4,4,4,8,8,8,8,16,16 -> final paddle_y=340; then 1 btn_up -> 336, dir=01.
REQ-030 paddle_y=516, two btn_down pulses -> 520 (y_upd high), then 520 held (y_upd low).
REQ-031 btn_up and btn_down in same cycle at paddle_y=300 -> paddle_y=300, dir=00, no y_upd; next btn_down -> 304.
REQ-032 IDLE_TIMEOUT=50: 5 btn_down pulses, gap 60 cycles, btn_down -> dir=00 after expiry, last step 4; with gap 40 -> step 8.

Source files
------------

// File: rtl/controller_pkg.sv
// Shared constants, state encoding and step-size rule for the paddle controllers.
package controller_pkg;
   localparam int SCREEN_H     = 600;
   localparam int PADDLE_H     = 80;
   localparam int Y_MAX        = SCREEN_H - PADDLE_H;
   localparam int Y_INIT       = 260;
   localparam int STEP_BASE    = 4;
   localparam int STEP_MAX     = 16;
   localparam int ACCEL_PULSES = 4;
   localparam int IDLE_TIMEOUT = 1_400_000;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_UP   = 2'b01,
      ST_DOWN = 2'b10
   } paddle_state_t;

   // Step grows with the streak: base, then double, then the maximum.
   function automatic logic [10:0] step_for(input logic [3:0] n);
      if (n <= 4'(ACCEL_PULSES))
         return 11'(STEP_BASE);
      else if (n <= 4'(2 * ACCEL_PULSES))
         return 11'(2 * STEP_BASE);
      else
         return 11'(STEP_MAX);
   endfunction
endpackage

// File: rtl/idle_timer.sv
// Counts cycles while the paddle is moving; flags expiry once TIMEOUT cycles pass
// without a clear. Frozen while hold is high, parked at zero while not running.
module idle_timer
   import controller_pkg::*;
#(
   parameter int unsigned TIMEOUT = IDLE_TIMEOUT
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic hold,
   input  logic run,
   output logic expire
);
   localparam logic [20:0] LIMIT = 21'(TIMEOUT);

   logic [20:0] count;

   always_ff @(posedge clk) begin
      if (rst || clear || !run)
         count <= '0;
      else if (!hold && count != LIMIT)
         count <= count + 21'd1;
   end

   assign expire = run && !hold && (count == LIMIT);
endmodule

// File: rtl/paddle_ctrl.sv
// One player's paddle: accelerating moves from debounced pulses, recentre request,
// pause handling and a streak that lapses after an idle period.
module paddle_ctrl
   import controller_pkg::*;
#(
   parameter int unsigned IDLE_TIMEOUT = controller_pkg::IDLE_TIMEOUT
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_up,
   input  logic       btn_down,
   input  logic       center,
   input  logic       freeze,
   output logic [9:0] paddle_y,
   output logic       y_upd,
   output logic [1:0] dir
);
   paddle_state_t state;
   logic [3:0]    streak;
   logic          qual_up, qual_dn, both_pressed, expire;
   logic [3:0]    streak_inc, n_up, n_dn;
   logic [10:0]   y_ext, step_up, step_dn, sum_dn;
   logic [9:0]    y_up_new, y_dn_new;

   assign qual_up      = btn_up & ~btn_down & ~center & ~freeze;
   assign qual_dn      = btn_down & ~btn_up & ~center & ~freeze;
   assign both_pressed = btn_up & btn_down & ~center & ~freeze;

   // Streak continues only in the current direction; anything else restarts at 1.
   assign streak_inc = (streak == 4'd15) ? 4'd15 : streak + 4'd1;
   assign n_up       = (state == ST_UP)   ? streak_inc : 4'd1;
   assign n_dn       = (state == ST_DOWN) ? streak_inc : 4'd1;

   assign y_ext    = {1'b0, paddle_y};
   assign step_up  = step_for(n_up);
   assign step_dn  = step_for(n_dn);
   assign sum_dn   = y_ext + step_dn;
   assign y_up_new = (y_ext < step_up) ? '0 : 10'(y_ext - step_up);
   assign y_dn_new = (sum_dn > 11'(Y_MAX)) ? 10'(Y_MAX) : 10'(sum_dn);

   idle_timer #(.TIMEOUT(IDLE_TIMEOUT)) u_idle_timer (
      .clk    (clk),
      .rst    (rst),
      .clear  (qual_up | qual_dn | both_pressed | center),
      .hold   (freeze),
      .run    (state != ST_IDLE),
      .expire (expire)
   );

   // Priority: center, then a move, then the both-pressed cancel, then timeout.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         streak   <= '0;
         paddle_y <= 10'(Y_INIT);
         y_upd    <= 1'b0;
      end else begin
         y_upd <= 1'b0;
         if (center) begin
            paddle_y <= 10'(Y_INIT);
            y_upd    <= (paddle_y != 10'(Y_INIT));
            streak   <= '0;
            state    <= ST_IDLE;
         end else if (qual_up) begin
            paddle_y <= y_up_new;
            y_upd    <= (y_up_new != paddle_y);
            streak   <= n_up;
            state    <= ST_UP;
         end else if (qual_dn) begin
            paddle_y <= y_dn_new;
            y_upd    <= (y_dn_new != paddle_y);
            streak   <= n_dn;
            state    <= ST_DOWN;
         end else if (both_pressed || expire) begin
            streak <= '0;
            state  <= ST_IDLE;
         end
      end
   end

   assign dir = state;
endmodule
